// File: rtl/mavg_multi_channel.sv
// Multi-channel moving average over 2^LOG2_LENGTH samples, one shared accumulator datapath.
// Optional round-half-up output stage enabled by defining MAVG_ROUND_EN (truncation otherwise).
module mavg_multi_channel #(
  parameter int BITWIDTH    = 16,
  parameter int CHANNELS    = 4,
  parameter int LOG2_LENGTH = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         EN,
  input  logic                         START_FLAG,
  input  logic [CHANNELS*BITWIDTH-1:0] DATA_IN,
  output logic [CHANNELS*BITWIDTH-1:0] DATA_OUT,
  output logic                         DATA_VALID,
  output logic                         BUSY,
  output logic                         OVERRUN
);
  localparam int N  = 1 << LOG2_LENGTH;
  localparam int AW = BITWIDTH + LOG2_LENGTH;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, READ, UPDATE, DONE} state_t;

  state_t                       state_reg, state_next;
  logic                         start_flag_reg;
  logic [CW-1:0]                ch_reg;
  logic [LOG2_LENGTH-1:0]       ptr_reg;
  logic [N-1:0]                 word_valid_reg;
  logic                         old_valid_reg;
  logic                         overrun_reg;

  logic [CHANNELS*BITWIDTH-1:0] in_flat;
  logic [CHANNELS*BITWIDTH-1:0] rd_flat;
  logic [CHANNELS*AW-1:0]       acc_flat;

  logic                         edge_seen;
  logic                         start;
  logic                         last_ch;
  logic [BITWIDTH-1:0]          new_sample;
  logic [BITWIDTH-1:0]          old_sample;
  logic [AW-1:0]                acc_next;
  logic [BITWIDTH-1:0]          avg;

  assign edge_seen  = START_FLAG & ~start_flag_reg;
  assign BUSY       = (state_reg != IDLE);
  assign start      = edge_seen & EN & ~BUSY;
  assign last_ch    = (ch_reg == CW'(CHANNELS - 1));
  assign DATA_VALID = (state_reg == DONE);
  assign OVERRUN    = overrun_reg;

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = READ;
      READ:    state_next = UPDATE;
      UPDATE:  state_next = last_ch ? DONE : READ;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Delay-line RAM holds no reset; a per-slot valid bit (shared pointer) makes unwritten slots read as 0.
  assign new_sample = in_flat[ch_reg*BITWIDTH +: BITWIDTH];
  assign old_sample = old_valid_reg ? rd_flat[ch_reg*BITWIDTH +: BITWIDTH] : '0;
  assign acc_next   = acc_flat[ch_reg*AW +: AW] + AW'(new_sample) - AW'(old_sample);

`ifdef MAVG_ROUND_EN
  localparam logic [AW:0] HALF = (AW+1)'(N / 2);
  assign avg = BITWIDTH'(({1'b0, acc_next} + HALF) >> LOG2_LENGTH);
`else
  assign avg = BITWIDTH'(acc_next >> LOG2_LENGTH);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      start_flag_reg <= 1'b0;
      ch_reg         <= '0;
      ptr_reg        <= '0;
      word_valid_reg <= '0;
      old_valid_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      start_flag_reg <= START_FLAG;
      if (edge_seen && EN && BUSY) overrun_reg <= 1'b1;
      if (state_reg == READ) old_valid_reg <= word_valid_reg[ptr_reg];
      if (state_reg == IDLE) ch_reg <= '0;
      else if (state_reg == UPDATE && !last_ch) ch_reg <= ch_reg + 1'b1;
      if (state_reg == DONE) begin
        ptr_reg                 <= ptr_reg + 1'b1;
        word_valid_reg[ptr_reg] <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [BITWIDTH-1:0] line_mem [N];
    logic [BITWIDTH-1:0] rd_reg;
    logic [BITWIDTH-1:0] in_reg;
    logic [BITWIDTH-1:0] out_reg;
    logic [AW-1:0]       acc_reg;
    logic                sel;

    assign sel = (state_reg == UPDATE) && (ch_reg == CW'(gi));

    always_ff @(posedge CLK) begin
      if (sel) line_mem[ptr_reg] <= new_sample;
      rd_reg <= line_mem[ptr_reg];
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        in_reg  <= '0;
        out_reg <= '0;
        acc_reg <= '0;
      end else begin
        if (start) in_reg <= DATA_IN[gi*BITWIDTH +: BITWIDTH];
        if (sel) begin
          acc_reg <= acc_next;
          out_reg <= avg;
        end
      end
    end

    assign in_flat[gi*BITWIDTH +: BITWIDTH]  = in_reg;
    assign rd_flat[gi*BITWIDTH +: BITWIDTH]  = rd_reg;
    assign acc_flat[gi*AW +: AW]             = acc_reg;
    assign DATA_OUT[gi*BITWIDTH +: BITWIDTH] = out_reg;
  end
endmodule

// File: tb/tb_mavg_multi_channel.sv
// Self-checking bench for mavg_multi_channel (8-bit, 2 channels, window 4) against a history-based model.
module tb_mavg_multi_channel;
  localparam int BW = 8;
  localparam int CH = 2;
  localparam int L  = 2;
  localparam int N  = 1 << L;
  localparam int LAT = 2 * CH + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             start_flag = 1'b0;
  logic [CH*BW-1:0] data_in = '0;
  logic [CH*BW-1:0] data_out;
  logic             data_valid, busy, overrun;

  int tests_run = 0;
  int fails = 0;
  logic [CH*BW-1:0] frames[$];
  logic exp_overrun = 1'b0;

  always #5 clk = ~clk;

  mavg_multi_channel #(.BITWIDTH(BW), .CHANNELS(CH), .LOG2_LENGTH(L)) dut (
    .CLK(clk), .RST(rst), .EN(en), .START_FLAG(start_flag),
    .DATA_IN(data_in), .DATA_OUT(data_out), .DATA_VALID(data_valid),
    .BUSY(busy), .OVERRUN(overrun)
  );

  // Average of the last N accepted samples of a channel; samples before reset count as 0.
  function automatic logic [BW-1:0] model_avg(input int ch);
    int sum = 0;
    int n = frames.size();
    for (int k = 0; k < N && k < n; k++) sum += int'(frames[n-1-k][ch*BW +: BW]);
`ifdef MAVG_ROUND_EN
    sum += N / 2;
`endif
    return BW'(sum / N);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start_flag = 1'b0; en = 1'b1;
    step(); step();
    rst = 1'b0;
    frames.delete();
    exp_overrun = 1'b0;
  endtask

  // Issues one start strobe and waits for DATA_VALID; reports what was observed.
  task automatic run_frame(input logic [CH*BW-1:0] din, input int en_drop,
                           output int lat, output logic [CH*BW-1:0] dout,
                           output int busy_cnt, output logic busy_after);
    data_in = din; start_flag = 1'b1;
    frames.push_back(din);
    step();
    start_flag = 1'b0;
    data_in = CH*BW'($urandom);
    lat = -1; busy_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == en_drop) en = 1'b0;
      busy_cnt += int'(busy);
      if (data_valid) begin lat = i; break; end
      step();
    end
    dout = data_out;
    step();
    busy_after = busy;
    en = 1'b1;
    $display("[TB] frame din=%h dout=%h lat=%0d busy_cycles=%0d", din, dout, lat, busy_cnt);
  endtask

  task automatic test_reset();
    int seen = 0;
    en = 1'b0; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin start_flag = ~start_flag; step(); end
    tests_run++;
    if (data_out !== '0 || data_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: out=%h valid=%b busy=%b ovr=%b, required all 0", data_out, data_valid, busy, overrun);
    end
    rst = 1'b0; frames.delete(); exp_overrun = 1'b0;
    for (int i = 0; i < 12; i++) begin
      start_flag = ~start_flag; step();
      if (data_valid || busy) seen++;
    end
    start_flag = 1'b0; step();
    tests_run++;
    if (seen != 0 || data_out !== '0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL idle_en_low: active_cycles=%0d out=%h ovr=%b, required 0/0/0", seen, data_out, overrun);
    end
    $display("[TB] reset/idle check done");
  endtask

  task automatic test_ramp();
    int e0[5] = '{33, 66, 99, 132, 132};
    int e1[5] = '{10, 20, 30, 40, 40};
    int lat, bc; logic ba; logic [CH*BW-1:0] d;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      run_frame({8'd40, 8'd132}, 0, lat, d, bc, ba);
      tests_run++;
      if (int'(d[7:0]) != e0[f] || int'(d[15:8]) != e1[f]) begin
        fails++;
        $display("FAIL ramp f%0d: ch0=%0d ch1=%0d, required %0d %0d", f, d[7:0], d[15:8], e0[f], e1[f]);
      end
      tests_run++;
      if (lat != LAT || bc != LAT || ba !== 1'b0) begin
        fails++;
        $display("FAIL ramp_timing f%0d: lat=%0d busy_cycles=%0d busy_after=%b, required %0d %0d 0", f, lat, bc, ba, LAT, LAT);
      end
    end
  endtask

  task automatic test_sliding();
    int e0[4] = '{125, 150, 175, 200};
    int lat, bc; logic ba; logic [CH*BW-1:0] d;
    logic [BW-1:0] c1;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      c1 = BW'($urandom);
      run_frame({c1, 8'd100}, 0, lat, d, bc, ba);
    end
    for (int f = 0; f < 4; f++) begin
      c1 = BW'($urandom);
      run_frame({c1, 8'd200}, 0, lat, d, bc, ba);
      tests_run++;
      if (int'(d[7:0]) != e0[f] || d[15:8] !== model_avg(1)) begin
        fails++;
        $display("FAIL sliding f%0d: ch0=%0d ch1=%0d, required %0d %0d", f, d[7:0], d[15:8], e0[f], model_avg(1));
      end
    end
  endtask

  task automatic test_rounding();
`ifdef MAVG_ROUND_EN
    int e0[2] = '{1, 2};
`else
    int e0[2] = '{0, 1};
`endif
    int lat, bc; logic ba; logic [CH*BW-1:0] d;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      run_frame({8'd0, 8'd3}, 0, lat, d, bc, ba);
      tests_run++;
      if (int'(d[7:0]) != e0[f]) begin
        fails++;
        $display("FAIL rounding f%0d: ch0=%0d, required %0d", f, d[7:0], e0[f]);
      end
    end
  endtask

  task automatic test_overrun_en();
    int lat = -1, seen = 0;
    logic [CH*BW-1:0] din, d;
    int bc; logic ba;
    do_reset();
    din = CH*BW'($urandom);
    data_in = din; start_flag = 1'b1; frames.push_back(din);
    step();
    start_flag = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) start_flag = 1'b1;
      if (i == 4) start_flag = 1'b0;
      if (data_valid) begin lat = i; break; end
      step();
    end
    exp_overrun = 1'b1;
    tests_run++;
    if (lat != LAT || data_out !== {model_avg(1), model_avg(0)} || overrun !== exp_overrun) begin
      fails++;
      $display("FAIL overrun_frame: lat=%0d out=%h ovr=%b, required %0d %h 1", lat, data_out,
               overrun, LAT, {model_avg(1), model_avg(0)});
    end
    $display("[TB] overrun frame din=%h dout=%h lat=%0d ovr=%b", din, data_out, lat, overrun);
    start_flag = 1'b0;
    step(); step();
    en = 1'b0; start_flag = 1'b1; step(); start_flag = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (data_valid || busy) seen++;
      step();
    end
    tests_run++;
    if (seen != 0 || overrun !== exp_overrun) begin
      fails++;
      $display("FAIL en_low_start: active_cycles=%0d ovr=%b, required 0 %b", seen, overrun, exp_overrun);
    end
    en = 1'b1;
    din = CH*BW'($urandom);
    run_frame(din, 2, lat, d, bc, ba);
    tests_run++;
    if (lat != LAT || d !== {model_avg(1), model_avg(0)} || overrun !== exp_overrun) begin
      fails++;
      $display("FAIL en_drop_midframe: lat=%0d out=%h ovr=%b, required %0d %h %b", lat, d, overrun,
               LAT, {model_avg(1), model_avg(0)}, exp_overrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    int seen = 0, lat, bc; logic ba; logic [CH*BW-1:0] d;
    data_in = {8'd55, 8'd200}; start_flag = 1'b1;
    step();
    start_flag = 1'b0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    frames.delete(); exp_overrun = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (data_valid) seen++;
      step();
    end
    tests_run++;
    if (seen != 0 || data_out !== '0 || busy !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_frame: valids=%0d out=%h busy=%b ovr=%b, required 0 0 0 0", seen, data_out, busy, overrun);
    end
    run_frame({8'd40, 8'd132}, 0, lat, d, bc, ba);
    tests_run++;
    if (d !== {8'd10, 8'd33} || lat != LAT) begin
      fails++;
      $display("FAIL after_reset_frame: out=%h lat=%0d, required 0a21 %0d", d, lat, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, gap; logic ba; logic [CH*BW-1:0] din, d;
    do_reset();
    for (int f = 0; f < 40; f++) begin
      din = CH*BW'($urandom);
      run_frame(din, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT)) : 0, lat, d, bc, ba);
      tests_run++;
      if (d !== {model_avg(1), model_avg(0)} || lat != LAT || bc != LAT || ba !== 1'b0) begin
        fails++;
        $display("FAIL random f%0d: out=%h lat=%0d busy=%0d/%b, required %h %0d %0d/0", f, d, lat, bc, ba,
                 {model_avg(1), model_avg(0)}, LAT, LAT);
      end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
    end
  endtask

  initial begin
    step();
    test_reset();
    test_ramp();
    test_sliding();
    test_rounding();
    test_overrun_en();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
